// File: rtl/row_sum_pkg.sv
// Shared types and constants for the row_sum_sequencer controller slice.
package row_sum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Half an LSB of led_byte, added on the final load when rounding is enabled.
  localparam int unsigned ROUND_ADD = 128;
  // Bit position of the first led_byte bit within total.
  localparam int unsigned LED_LSB   = 8;

endpackage

// File: rtl/row_sum_sequencer_valid_delay_line.sv
// valid_delay_line: PIPE_LAT-deep valid shift register mirroring the adder-tree
// pipeline. tap_o marks the cycle in which the tree's sum_in belongs to an
// issued row. empty_o reports that no row remains outstanding once the current
// tap has been consumed, so the controller can finish on the same edge as the
// final accumulate.
module valid_delay_line #(
  parameter int unsigned PIPE_LAT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic in_i,
  output logic tap_o,
  output logic empty_o
);

  logic [PIPE_LAT-1:0] dl_q;
  logic [PIPE_LAT-1:0] dl_d;

  // Next contents: shift in the new valid, or wipe everything on clear.
  always_comb begin
    dl_d = '0;
    if (!clear_i) begin
      dl_d[0] = in_i;
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        dl_d[i] = dl_q[i-1];
      end
    end
  end

  // Register the shift stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_q <= '0;
    end else begin
      dl_q <= dl_d;
    end
  end

  assign tap_o   = dl_q[PIPE_LAT-1];
  assign empty_o = ~|dl_d;

endmodule

// File: rtl/row_sum_sequencer.sv
// row_sum_sequencer: issues ROWS rows to the 8-lane adder tree, accumulates
// the returned per-row sums and hands the total to the consumer via
// result_valid/result_ready.
// Build option: define ROW_SUM_ROUND_EN to add ROUND_ADD to the final total so
// that led_byte is rounded to nearest instead of truncated.
module row_sum_sequencer
  import row_sum_pkg::*;
#(
  parameter int unsigned ROWS     = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned PIPE_LAT = 3,
  parameter int unsigned SUM_W    = 32,
  parameter int unsigned ACC_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [AW-1:0]    row_addr,
  output logic             row_valid,
  input  logic [SUM_W-1:0] sum_in,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [ACC_W-1:0] total,
  output logic [7:0]       led_byte
);

  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic [ACC_W-1:0] total_q, total_d;
  logic             enter_issue;
  logic             last_row;
  logic             tap;
  logic             dl_empty;

  valid_delay_line #(
    .PIPE_LAT (PIPE_LAT)
  ) u_valid_delay_line (
    .clk     (clk),
    .rst     (rst),
    .clear_i (enter_issue),
    .in_i    (row_valid),
    .tap_o   (tap),
    .empty_o (dl_empty)
  );

  assign last_row = (addr_q == AW'(ROWS - 1));

  // Run sequencing; DONE with result_ready and start re-enters ISSUE directly.
  always_comb begin
    state_d     = state_q;
    enter_issue = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = ISSUE;
          enter_issue = 1'b1;
        end
      end
      ISSUE: begin
        if (last_row) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (dl_empty) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (result_ready) begin
          if (start) begin
            state_d     = ISSUE;
            enter_issue = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Row address, accumulator and result register next-state.
  // The DRAIN->DONE load uses acc_sum so the final tap lands in total on the
  // same edge it is accumulated.
  always_comb begin
    addr_d = addr_q;
    if (enter_issue) begin
      addr_d = '0;
    end else if (state_q == ISSUE && !last_row) begin
      addr_d = addr_q + AW'(1);
    end

    acc_sum = acc_q + (tap ? ACC_W'(sum_in) : '0);
    acc_d   = enter_issue ? '0 : acc_sum;

    total_d = total_q;
    if (state_q == DRAIN && dl_empty) begin
`ifdef ROW_SUM_ROUND_EN
      total_d = acc_sum + ACC_W'(ROUND_ADD);
`else
      total_d = acc_sum;
`endif
    end
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      acc_q   <= '0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      acc_q   <= acc_d;
      total_q <= total_d;
    end
  end

  assign row_addr     = addr_q;
  assign row_valid    = (state_q == ISSUE);
  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign total        = total_q;
  assign led_byte     = total_q[LED_LSB +: 8];

endmodule

// File: tb/tb_row_sum_sequencer.sv
// Self-checking bench for row_sum_sequencer with a behavioural adder-tree
// model and a scoreboard of expected totals.
module tb_row_sum_sequencer;

  localparam int ROWS = 32;
  localparam int AW   = 5;
  localparam int PL   = 3;

  logic          clk = 1'b0;
  logic          rst, start, result_ready;
  logic [AW-1:0] row_addr;
  logic          row_valid, busy, result_valid;
  logic [31:0]   sum_in, total;
  logic [7:0]    led_byte;

  logic          s_start, s_ready;
  logic [0:0]    s_row_addr;
  logic          s_row_valid, s_busy, s_result_valid;
  logic [31:0]   s_sum_in, s_total;
  logic [7:0]    s_led_byte;

  always #5 clk = ~clk;

  row_sum_sequencer #(
    .ROWS(ROWS), .AW(AW), .PIPE_LAT(PL), .SUM_W(32), .ACC_W(32)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .row_addr(row_addr),
    .row_valid(row_valid), .sum_in(sum_in), .busy(busy),
    .result_valid(result_valid), .result_ready(result_ready),
    .total(total), .led_byte(led_byte)
  );

  row_sum_sequencer #(
    .ROWS(2), .AW(1), .PIPE_LAT(1), .SUM_W(32), .ACC_W(32)
  ) u_small (
    .clk(clk), .rst(rst), .start(s_start), .row_addr(s_row_addr),
    .row_valid(s_row_valid), .sum_in(s_sum_in), .busy(s_busy),
    .result_valid(s_result_valid), .result_ready(s_ready),
    .total(s_total), .led_byte(s_led_byte)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Adder-tree model: every lane of a row carries lane_val[row], so a row sums to 8*lane_val.
  logic [7:0]    lane_val [ROWS];
  bit            tv [PL];
  logic [AW-1:0] ta [PL];

  always @(posedge clk) begin
    tv[0] <= row_valid;
    ta[0] <= row_addr;
    for (int i = 1; i < PL; i++) begin
      tv[i] <= tv[i-1];
      ta[i] <= ta[i-1];
    end
  end

  assign sum_in = tv[PL-1] ? (32'(lane_val[ta[PL-1]]) * 32'd8) : 32'hDEAD_BEEF;

  bit   sv;
  logic sa;
  always @(posedge clk) begin
    sv <= s_row_valid;
    sa <= s_row_addr[0];
  end
  assign s_sum_in = sv ? (sa ? 32'd1000 : 32'd234) : 32'hBAD0_0000;

  localparam logic [31:0] RND = 
`ifdef ROW_SUM_ROUND_EN
    32'd128;
`else
    32'd0;
`endif

  function automatic logic [31:0] model_total();
    logic [31:0] s;
    s = RND;
    for (int r = 0; r < ROWS; r++) s += 32'(lane_val[r]) * 32'd8;
    return s;
  endfunction

  // Scoreboard: push on an accepted start, pop and compare on handshake.
  logic [31:0] sb_q [$];
  logic [31:0] sb_exp;

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (result_valid && result_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", 64'(sb_q.size()), 64'd1);
        end else begin
          sb_exp = sb_q.pop_front();
          check_eq("sb_total", total, sb_exp);
        end
      end
      if (start && (!busy || (result_valid && result_ready)))
        sb_q.push_back(model_total());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_result(input int max_cyc, inout int cyc);
    while (!result_valid && cyc < max_cyc) begin
      tick();
      cyc++;
    end
    check_eq("result_valid_seen", result_valid, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_row_addr"},     row_addr, '0);
    check_eq({tag, "_row_valid"},    row_valid, 1'b0);
    check_eq({tag, "_busy"},         busy, 1'b0);
    check_eq({tag, "_result_valid"}, result_valid, 1'b0);
    check_eq({tag, "_total"},        total, 32'd0);
    check_eq({tag, "_led_byte"},     led_byte, 8'd0);
  endtask

  int          cyc;
  logic [31:0] t0;

  initial begin
    rst = 1'b1; start = 1'b0; result_ready = 1'b0;
    s_start = 1'b0; s_ready = 1'b0;
    for (int r = 0; r < ROWS; r++) lane_val[r] = 8'd1;
    tick(); tick();
    check_reset_outputs("reset");
    check_eq("reset_small_valid", s_result_valid, 1'b0);
    check_eq("reset_small_total", s_total, 32'd0);
    rst = 1'b0;
    tick();

    // Run A: all lanes 1, stray start pulses in ISSUE, DRAIN and DONE.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      check_eq("issue_valid", row_valid, 1'b1);
      check_eq("issue_addr", row_addr, 64'(r));
      if (r == 5) start = 1'b1;
      tick();
      start = 1'b0;
    end
    check_eq("drain_valid", row_valid, 1'b0);
    check_eq("drain_busy", busy, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 34;
    wait_result(80, cyc);
    check_eq("a_latency", 64'(cyc), 64'd36);
    check_eq("a_total", total, 32'd256 + RND);
    check_eq("a_led", led_byte, 8'h01);
    t0 = total;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("hold_total", total, t0);
      check_eq("hold_valid", result_valid, 1'b1);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check_eq("a_released_valid", result_valid, 1'b0);
    check_eq("a_released_busy", busy, 1'b0);
    tick(); tick();
    check_eq("a_idle_no_queue", busy, 1'b0);
    check_eq("a_idle_total_kept", total, t0);

    // Run B: all lanes 0xFF, then back-to-back start with result_ready.
    for (int r = 0; r < ROWS; r++) lane_val[r] = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    wait_result(80, cyc);
    check_eq("b_latency", 64'(cyc), 64'd36);
`ifdef ROW_SUM_ROUND_EN
    check_eq("b_total", total, 32'h0000_FF80);
`else
    check_eq("b_total", total, 32'h0000_FF00);
`endif
    check_eq("b_led", led_byte, 8'hFF);
    t0 = total;
    result_ready = 1'b1;
    start = 1'b1;
    tick();
    result_ready = 1'b0;
    start = 1'b0;
    check_eq("b2b_row_valid", row_valid, 1'b1);
    check_eq("b2b_row_addr", row_addr, '0);
    check_eq("b2b_result_valid", result_valid, 1'b0);
    cyc = 1;
    wait_result(80, cyc);
    check_eq("b2b_latency", 64'(cyc), 64'd36);
    check_eq("b2b_total_same", total, t0);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;

    // Run C: reset at row_addr 10, then a clean run on fresh random data.
    for (int r = 0; r < ROWS; r++) lane_val[r] = 8'($urandom_range(0, 255));
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check_eq("c_abort_addr", row_addr, 64'd10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("midrun_reset");
    for (int i = 0; i < 5; i++) tick();
    for (int r = 0; r < ROWS; r++) lane_val[r] = 8'($urandom_range(0, 255));
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    wait_result(80, cyc);
    check_eq("c_total", total, model_total());
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;

    // Run D: ROWS=2, PIPE_LAT=1 instance.
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    cyc = 1;
    while (!s_result_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check_eq("small_valid_seen", s_result_valid, 1'b1);
    check_eq("small_latency", 64'(cyc), 64'd4);
    check_eq("small_total", s_total, 32'd1234 + RND);
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0;
    check_eq("small_released", s_result_valid, 1'b0);

    tick();
    check_eq("sb_leftover", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
